// File: rtl/usrt_tx_feeder.sv
// rtl/usrt_tx_feeder.sv - byte FIFO draining into a buffered USRT via LOAD/SEND/NINTO handshake
//
// Purpose: accepts host bytes into a DEPTH-entry circular FIFO and hands them one at a
// time to the USRT transmit buffer: one-cycle LOAD (with Tx_Data_In), one-cycle SEND,
// then waits for NINTO to pulse low and return high before the next byte.
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   RESET        in   asynchronous active-low reset
//   wr_en        in   host write strobe, one byte per cycle (dropped while full)
//   wr_data      in   host byte
//   full         out  FIFO holds DEPTH bytes
//   empty        out  FIFO holds no bytes
//   count        out  FIFO occupancy 0..DEPTH
//   busy         out  a byte is being handed to / transmitted by the USRT
//   LOAD         out  one-cycle strobe, Tx_Data_In valid
//   SEND         out  one-cycle strobe, start transmission
//   Tx_Data_In   out  byte presented to the USRT, held until the next LOAD
//   NINTO        in   active-low transmit-complete from the USRT
//   tx_err       out  sticky transmitter-stall flag
//
// Build option: USRT_TX_FEEDER_TIMEOUT_EN enables the WAIT_DONE watchdog (TIMEOUT cycles)
// that sets tx_err and abandons the byte; without it tx_err is 0 and the wait is unbounded.

module usrt_tx_feeder #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          LOAD,
  output logic          SEND,
  output logic [7:0]    Tx_Data_In,
  input  logic          NINTO,
  output logic          tx_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_ST   = 3'd1,
    SEND_ST   = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    tx_data_q;
  logic          push, pop, timeout_hit;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // full is taken from the registered count, so a write is dropped even if a pop
  // frees a slot on the same edge.
  assign push = wr_en && !full;
  // The pop coincides with the IDLE -> LOAD_ST transition so the head byte and LOAD
  // appear together.
  assign pop  = (state_q == IDLE) && !empty;

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tx_data_q <= 8'h00;
    end else if (pop) begin
      tx_data_q <= mem_q[rptr_q];
    end
  end

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. RELEASE waits for NINTO to go back high so a held-low
  // completion is only ever counted once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty) state_d = LOAD_ST;
      LOAD_ST:   state_d = SEND_ST;
      SEND_ST:   state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!NINTO)           state_d = RELEASE;
        else if (timeout_hit) state_d = IDLE;
      end
      RELEASE:   if (NINTO) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decode the state register directly, so LOAD/SEND are glitch-free and,
  // since each state lasts one cycle, never high on consecutive cycles.
  always_comb begin
    LOAD       = (state_q == LOAD_ST);
    SEND       = (state_q == SEND_ST);
    busy       = (state_q != IDLE);
    Tx_Data_In = tx_data_q;
  end

`ifdef USRT_TX_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          tx_err_q, tx_err_d;

  // Counter is held at 0 outside WAIT_DONE, so it starts from 0 on entry and the
  // error fires on the edge after it has counted TIMEOUT cycles.
  assign timeout_hit = (state_q == WAIT_DONE) && NINTO && (to_cnt_q == CW'(TIMEOUT));

  always_comb begin
    to_cnt_d = to_cnt_q;
    tx_err_d = tx_err_q | timeout_hit;
    if (state_q != WAIT_DONE)            to_cnt_d = '0;
    else if (to_cnt_q != CW'(TIMEOUT))   to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      to_cnt_q <= '0;
      tx_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tx_err_q <= tx_err_d;
    end
  end

  assign tx_err = tx_err_q;
`else
  assign timeout_hit = 1'b0;
  assign tx_err      = 1'b0;
`endif

endmodule

// File: tb/tb_usrt_tx_feeder.sv
// tb/tb_usrt_tx_feeder.sv - self-checking bench for usrt_tx_feeder
module tb_usrt_tx_feeder;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 15;
`ifdef USRT_TX_FEEDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          NINTO = 1'b1;
  logic          full, empty, busy, LOAD, SEND, tx_err;
  logic [AW:0]   count;
  logic [7:0]    Tx_Data_In;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  usrt_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .LOAD(LOAD), .SEND(SEND), .Tx_Data_In(Tx_Data_In),
    .NINTO(NINTO), .tx_err(tx_err)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: a byte queue plus one in-flight transaction described by its
  // age in cycles since LOAD (0 = LOAD cycle, 1 = SEND cycle, >=2 = awaiting NINTO).
  logic [7:0] mq[$];
  bit         m_fl = 0, m_low = 0, m_err = 0, m_acc;
  int         m_age = 0;
  logic [7:0] m_tx = 8'h00;

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      mq.delete(); m_fl = 0; m_low = 0; m_err = 0; m_age = 0; m_tx = 8'h00;
    end else begin
      m_acc = wr_en && (mq.size() < DEPTH);
      if (!m_fl) begin
        if (mq.size() != 0) begin
          m_tx = mq.pop_front(); m_fl = 1; m_age = 0; m_low = 0;
        end
      end else begin
        if (m_age >= 2) begin
          if (!m_low) begin
            if (!NINTO) m_low = 1;
            else if (TO_EN && m_age == TIMEOUT + 2) begin m_err = 1; m_fl = 0; end
          end else if (NINTO) m_fl = 0;
        end
        m_age++;
      end
      if (m_acc) mq.push_back(wr_data);
    end
  end

  bit cmp_en = 0;
  always @(negedge CLOCK) begin
    if (cmp_en) begin
      chk("m_count", count, mq.size());
      chk("m_full",  full,  mq.size() == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_busy",  busy,  m_fl);
      chk("m_load",  LOAD,  m_fl && m_age == 0);
      chk("m_send",  SEND,  m_fl && m_age == 1);
      chk("m_tx",    Tx_Data_In, m_tx);
      chk("m_err",   tx_err, m_err);
    end
  end

  // USRT stand-in: after SEND, wait resp_delay cycles, pull NINTO low resp_low cycles.
  bit rand_n = 0, resp_en = 0;
  int resp_delay = 1, resp_low = 1, rise_cyc = 0;
  initial begin
    forever begin
      @(negedge CLOCK);
      if (rand_n) NINTO = 1'($urandom_range(0, 1));
      else if (resp_en && SEND) begin
        repeat (resp_delay) @(negedge CLOCK);
        NINTO = 1'b0;
        repeat (resp_low) @(negedge CLOCK);
        NINTO = 1'b1;
        rise_cyc = cyc;
      end else NINTO = 1'b1;
    end
  end

  logic [7:0] loads[$];
  int load_cyc = 0;
  always @(negedge CLOCK) begin
    if (LOAD) begin loads.push_back(Tx_Data_In); load_cyc = cyc; end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge CLOCK); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin @(posedge CLOCK); #1; end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic rst_pulse();
    @(posedge CLOCK); #1 RESET = 1'b0;
    #2 RESET = 1'b1;
  endtask

  int diff;

  initial begin
    // Reset with random inputs
    @(posedge CLOCK); cmp_en = 1;
    rand_n = 1;
    for (int i = 0; i < 10; i++) begin
      #1 wr_en = 1'($urandom_range(0, 1)); wr_data = 8'($urandom);
      #2 chk("rst_outs", {full, empty, count, busy, LOAD, SEND, Tx_Data_In, tx_err},
             {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
      @(posedge CLOCK);
    end
    wr_en = 1'b0; rand_n = 0;
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK); #1;
      chk("idle_quiet", {LOAD, SEND}, 2'b00);
    end

    // Single byte
    resp_en = 1; resp_delay = 1; resp_low = 1;
    wr(8'hA5);
    @(posedge CLOCK); #1;
    chk("sb_load", LOAD, 1'b1); chk("sb_tx", Tx_Data_In, 8'hA5); chk("sb_nosend", SEND, 1'b0);
    @(posedge CLOCK); #1;
    chk("sb_send", SEND, 1'b1); chk("sb_noload", LOAD, 1'b0);
    repeat (2) @(posedge CLOCK); #1;
    chk("sb_busy_release", busy, 1'b1);
    @(posedge CLOCK); #1;
    chk("sb_idle", busy, 1'b0); chk("sb_empty", empty, 1'b1);

    // Fill and order: primer byte 00 keeps the FSM busy while 01..08 fill the FIFO
    loads.delete(); resp_delay = 20;
    for (int v = 0; v <= 8; v++) wr(8'(v));
    chk("fill_count", count, 4'd8); chk("fill_full", full, 1'b1);
    wr(8'hFF);
    chk("drop_count", count, 4'd8); chk("drop_full", full, 1'b1);
    for (int i = 0; i < 1000 && !(loads.size() == 9 && !busy); i++) begin @(posedge CLOCK); #1; end
    chk("fill_nloads", loads.size(), 9);
    for (int i = 0; i < 9 && i < loads.size(); i++) chk("fill_order", loads[i], i);
    chk("fill_empty", empty, 1'b1);

    // Held NINTO: second LOAD exactly two cycles after NINTO is raised
    loads.delete(); resp_delay = 2; resp_low = 50;
    wr(8'h11); wr(8'h22);
    for (int i = 0; i < 300 && loads.size() < 2; i++) begin @(posedge CLOCK); #1; end
    diff = load_cyc - rise_cyc;
    chk("held_nloads", loads.size(), 2);
    chk("held_second", loads.size() > 1 ? loads[1] : 8'h00, 8'h22);
    chk("held_gap", diff, 2);
    wait_idle(300);
    chk("held_total", loads.size(), 2);

    // Timeout: USRT never answers
    resp_en = 0;
    wr(8'h33); wr(8'h44);
    repeat (17) @(posedge CLOCK); #1;
    chk("to_pre_err", tx_err, 1'b0); chk("to_pre_busy", busy, 1'b1);
    @(posedge CLOCK); #1;
    chk("to_err", tx_err, TO_EN); chk("to_busy", busy, !TO_EN);
    @(posedge CLOCK); #1;
    chk("to_next_load", LOAD, TO_EN); chk("to_next_tx", Tx_Data_In, TO_EN ? 8'h44 : 8'h33);
    rst_pulse();
    #1 chk("to_err_cleared", tx_err, 1'b0);

    // Reset in WAIT_DONE with three bytes queued
    @(posedge CLOCK); #1;
    wr(8'h50); wr(8'h51); wr(8'h52); wr(8'h53);
    chk("mid_count", count, 4'd3); chk("mid_busy", busy, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_count", count, 4'd0); chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_busy", busy, 1'b0); chk("mid_rst_tx", Tx_Data_In, 8'h00);
    @(posedge CLOCK); #1 RESET = 1'b1;
    repeat (5) @(posedge CLOCK);
    #1 chk("post_quiet", {LOAD, SEND, busy}, 3'b000);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule

// File: doc/usrt_tx_feeder.md
# usrt_tx_feeder

Transmit-side feeder that sits directly upstream of the buffered USRT. It accepts bytes from a host write port into a small FIFO and drains them one at a time into the USRT transmit buffer. For each byte it issues a one-cycle LOAD, then a one-cycle SEND, then waits for the transmitter's completion handshake on NINTO before starting the next byte. It also reports occupancy, and optionally flags a stalled transmitter.

## Interface
- DEPTH, 8, FIFO depth in bytes; power of two, minimum 2
- AW, 3, log2(DEPTH)
- TIMEOUT, 1023, max cycles to wait for NINTO low before error (Configuration)
- CLOCK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- wr_en  in  1  host write strobe; one byte per cycle
- wr_data  in  8  host byte
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  AW+1  FIFO occupancy, 0..DEPTH
- busy  out  1  FSM not in IDLE
- LOAD  out  1  one-cycle strobe to USRT transmit buffer
- SEND  out  1  one-cycle strobe to start transmission
- Tx_Data_In  out  8  byte presented to USRT, valid while LOAD=1 and held until next LOAD
- NINTO  in  1  active-low transmit-complete from USRT
- tx_err  out  1  sticky timeout flag (Configuration)

## Operation
- FIFO: circular, write pointer and read pointer AW bits wide, wrap DEPTH-1 -> 0; count tracks occupancy.
- A write with wr_en=1 and full=1 is dropped; pointers and count do not change. This applies even if a pop happens in the same cycle.
- A simultaneous accepted write and pop leaves count unchanged.
- FSM states:
  - IDLE: if count!=0 -> LOAD_ST.
  - LOAD_ST: LOAD=1, Tx_Data_In<=head byte, pop FIFO -> SEND_ST.
  - SEND_ST: SEND=1 -> WAIT_DONE.
  - WAIT_DONE: on NINTO==0 -> RELEASE.
  - RELEASE: on NINTO==1 -> IDLE.
- RELEASE ensures a held-low NINTO is never counted twice.
- LOAD and SEND are registered, mutually exclusive, and never high for two consecutive cycles.
- Reset mid-frame: every output returns to its reset value, the FIFO is emptied, and the FSM goes to IDLE. Any frame already in the USRT is not aborted.
- Reset values: full=0, empty=1, count=0, busy=0, LOAD=0, SEND=0, Tx_Data_In=8'h00, tx_err=0.

## Timing
- Write accepted at edge k (FIFO previously empty, FSM in IDLE): LOAD=1 for cycle k+1..k+2, SEND=1 for cycle k+2..k+3.
- NINTO sampled low at edge m: RELEASE from m. NINTO sampled high at edge n>m: IDLE from n. With FIFO non-empty, the next LOAD is asserted from n+1.
- Minimum per-byte overhead is 4 cycles beyond the USRT frame time.
- full, empty and count update on the edge that changes occupancy; no combinational path from wr_en.

## Configuration
- USRT_TX_FEEDER_TIMEOUT_EN defined:
  - A cycle counter (width to hold TIMEOUT) clears on entering WAIT_DONE.
  - If it reaches TIMEOUT while still in WAIT_DONE, tx_err sets (sticky until RESET) and the FSM goes to IDLE. The popped byte is lost.
- Macro undefined: no counter; tx_err is tied 0; WAIT_DONE waits indefinitely.

## Test plan
- Reset: hold RESET=0 with random inputs -> all outputs at reset values; release, idle 10 cycles -> no LOAD or SEND.
- Single byte: write 8'hA5 at edge k -> LOAD with Tx_Data_In=8'hA5 in cycle k+1, SEND in k+2. Drive NINTO low 1 cycle -> busy=0 after NINTO high is sampled; empty=1.
- Fill and order: write 8'h01..8'h08 back-to-back -> full=1, count=8. A ninth write of 8'hFF is dropped. Model USRT with 20-cycle NINTO response -> Tx_Data_In sequence is 01..08, exactly 8 LOADs.
- Held NINTO: keep NINTO low 50 cycles after SEND with 2 bytes queued -> second LOAD only after NINTO returns high; no double completion.
- Timeout (macro defined, TIMEOUT=15): keep NINTO high after SEND -> tx_err=1 sixteen cycles after entering WAIT_DONE, FSM back to IDLE, next queued byte loads. With macro undefined, the FSM stays in WAIT_DONE.
- Reset mid-operation: assert RESET in WAIT_DONE with count=3 -> count=0, empty=1, busy=0 immediately (asynchronous).
